// File: rtl/i2c_master_txn_seq.sv
// i2c_master_txn_seq: register-transaction sequencer driving an I2C byte controller
// Optional feature macro: I2C_SEQ_TIMEOUT_EN (per-command watchdog, TO_W/TO_CYC).
// Ports:
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   Req, Req_rnw, Dev_addr,
//   Reg_addr, Wr_data               host request (sampled only while idle)
//   Busy, Done, Rd_data,
//   Nack_err, Al_err, To_err        host status / results
//   Start, Stop, Read, Write,
//   Tx_ack, Txr                     byte-controller command (held until I2C_done)
//   Rxr, Rx_ack, I2C_done, I2C_al   byte-controller response
module i2c_master_txn_seq #(
    parameter int TO_W   = 16,
    parameter int TO_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Req,
    input  logic       Req_rnw,
    input  logic [6:0] Dev_addr,
    input  logic [7:0] Reg_addr,
    input  logic [7:0] Wr_data,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Rd_data,
    output logic       Nack_err,
    output logic       Al_err,
    output logic       To_err,
    output logic       Start,
    output logic       Stop,
    output logic       Read,
    output logic       Write,
    output logic       Tx_ack,
    output logic [7:0] Txr,
    input  logic [7:0] Rxr,
    input  logic       Rx_ack,
    input  logic       I2C_done,
    input  logic       I2C_al
);
    typedef enum logic [2:0] {IDLE, ADDR_W, REG, WDATA, RSTART, RDATA, NSTOP, FIN} state_t;

    state_t      state_q, state_d;
    logic        cmd_q, cmd_d;
    logic        rnw_q, rnw_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdat_q, wdat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rd_q, rd_d;
    logic        nack_q, nack_d;
    logic        al_q, al_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        txack_q, txack_d;
    logic [7:0]  txr_q, txr_d;
    logic        accept, is_cmd, leave, tmo;

    assign accept = state_q == IDLE && Req;
    assign is_cmd = state_q != IDLE && state_q != FIN;
    // Completion only counts for a command actually on the bus; arbitration loss overrides it.
    assign leave  = cmd_q && I2C_done && !I2C_al;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic            to_q, to_d;

    // wdog_q counts completed asserted cycles of the current command; the gap cycle clears it.
    assign tmo    = cmd_q && !I2C_done && wdog_q == TO_W'(TO_CYC - 1);
    assign wdog_d = (cmd_q && cmd_d) ? wdog_q + 1'b1 : '0;
    assign to_d   = accept ? 1'b0 : (is_cmd && !I2C_al && tmo) ? 1'b1 : to_q;
    assign To_err = to_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wdog_q <= '0;
            to_q   <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            to_q   <= to_d;
        end
    end
`else
    assign tmo    = 1'b0;
    assign To_err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cmd_q   <= 1'b0;
            rnw_q   <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            nack_q  <= 1'b0;
            al_q    <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            txack_q <= 1'b0;
            txr_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rnw_q   <= rnw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdat_q  <= wdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            nack_q  <= nack_d;
            al_q    <= al_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            read_q  <= read_d;
            write_q <= write_d;
            txack_q <= txack_d;
            txr_q   <= txr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = Req ? ADDR_W : IDLE;
        else if (state_q == FIN)
            state_d = IDLE;
        else if (I2C_al || tmo)
            state_d = FIN;
        else if (leave)
            case (state_q)
                ADDR_W:  state_d = Rx_ack ? NSTOP : REG;
                REG:     state_d = Rx_ack ? NSTOP : (rnw_q ? RSTART : WDATA);
                RSTART:  state_d = Rx_ack ? NSTOP : RDATA;
                default: state_d = FIN;
            endcase
    end

    always_comb begin
        // A command state spends one cycle with nothing asserted, then holds its command until done.
        cmd_d   = is_cmd && !I2C_al && !tmo && !leave;
        start_d = cmd_d && (state_q == ADDR_W || state_q == RSTART);
        write_d = cmd_d && (state_q == ADDR_W || state_q == REG || state_q == WDATA || state_q == RSTART);
        stop_d  = cmd_d && (state_q == WDATA || state_q == RDATA || state_q == NSTOP);
        read_d  = cmd_d && state_q == RDATA;
        txack_d = read_d;
        txr_d   = !cmd_d ? 8'h00 :
                  (state_q == REG)   ? reg_q :
                  (state_q == WDATA) ? wdat_q :
                  (state_q == RDATA || state_q == NSTOP) ? 8'h00 :
                  {dev_q, state_q == RSTART};
        busy_d  = state_d != IDLE && state_d != FIN;
        done_d  = state_d == FIN;
        rnw_d   = accept ? Req_rnw : rnw_q;
        dev_d   = accept ? Dev_addr : dev_q;
        reg_d   = accept ? Reg_addr : reg_q;
        wdat_d  = accept ? Wr_data : wdat_q;
        rd_d    = (leave && state_q == RDATA) ? Rxr : rd_q;
        nack_d  = accept ? 1'b0 :
                  (leave && state_q == WDATA) ? Rx_ack :
                  (leave && state_q == NSTOP) ? 1'b1 : nack_q;
        al_d    = accept ? 1'b0 : (is_cmd && I2C_al) ? 1'b1 : al_q;
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Rd_data  = rd_q;
    assign Nack_err = nack_q;
    assign Al_err   = al_q;
    assign Start    = start_q;
    assign Stop     = stop_q;
    assign Read     = read_q;
    assign Write    = write_q;
    assign Tx_ack   = txack_q;
    assign Txr      = txr_q;
endmodule

// File: tb/tb_i2c_master_txn_seq.sv
// tb_i2c_master_txn_seq: scoreboard bench with a byte-controller response model
module tb_i2c_master_txn_seq;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TOC = 100;
`else
    localparam int TOC = 50000;
`endif
    // command flags {start, stop, read, write, tx_ack}
    localparam logic [4:0] F_AW = 5'b10010, F_RG = 5'b00010, F_WD = 5'b01010;
    localparam logic [4:0] F_RD = 5'b01101, F_NS = 5'b01000;

    logic Clk = 0, Rst_n = 0, Req = 0, Req_rnw = 0;
    logic [6:0] Dev_addr = 0;
    logic [7:0] Reg_addr = 0, Wr_data = 0, Rxr = 0;
    logic Rx_ack = 0, I2C_done = 0, I2C_al = 0;
    logic Busy, Done, Nack_err, Al_err, To_err, Start, Stop, Read, Write, Tx_ack;
    logic [7:0] Rd_data, Txr;

    i2c_master_txn_seq #(.TO_W(16), .TO_CYC(TOC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Req_rnw(Req_rnw), .Dev_addr(Dev_addr),
        .Reg_addr(Reg_addr), .Wr_data(Wr_data), .Busy(Busy), .Done(Done), .Rd_data(Rd_data),
        .Nack_err(Nack_err), .Al_err(Al_err), .To_err(To_err), .Start(Start), .Stop(Stop),
        .Read(Read), .Write(Write), .Tx_ack(Tx_ack), .Txr(Txr), .Rxr(Rxr), .Rx_ack(Rx_ack),
        .I2C_done(I2C_done), .I2C_al(I2C_al)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       kind;
        logic [4:0] fl;
        logic [7:0] txr;
        logic [2:0] err;
        logic       chk_rd;
        logic [7:0] rd;
    } exp_t;
    typedef struct {
        logic       ack;
        logic [7:0] rxr;
        int         dly;
    } resp_t;

    exp_t  sb[$];
    resp_t rq[$];
    int    n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic void push_cmd(input logic [4:0] fl, input logic [7:0] txr);
        exp_t e;
        e.kind = 1'b0; e.fl = fl; e.txr = txr; e.err = 3'b000; e.chk_rd = 1'b0; e.rd = 8'h00;
        sb.push_back(e);
    endfunction

    function automatic void push_done(input logic [2:0] err, input logic chk_rd, input logic [7:0] rd);
        exp_t e;
        e.kind = 1'b1; e.fl = 5'b0; e.txr = 8'h00; e.err = err; e.chk_rd = chk_rd; e.rd = rd;
        sb.push_back(e);
    endfunction

    function automatic void push_resp(input logic ack, input logic [7:0] rxr, input int dly);
        resp_t r;
        r.ack = ack; r.rxr = rxr; r.dly = dly;
        rq.push_back(r);
    endfunction

    function automatic logic [63:0] outs();
        return {Busy, Done, Rd_data, Nack_err, Al_err, To_err, Start, Stop, Read, Write, Tx_ack, Txr};
    endfunction

    // Monitor: a new command or a Done pulse pops the next expected item.
    logic prev_cmd = 0;
    logic cur_cmd;
    exp_t me;
    always @(negedge Clk) begin
        cur_cmd = Start | Stop | Read | Write;
        if (Rst_n && cur_cmd && !prev_cmd) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_cmd: got unexpected command txr=%0h expected none", Txr);
            end else begin
                me = sb.pop_front();
                chk("sb_cmd", {1'b0, Start, Stop, Read, Write, Tx_ack, Txr}, {me.kind, me.fl, me.txr});
            end
        end
        if (Rst_n && Done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_done: got unexpected Done expected none");
            end else begin
                me = sb.pop_front();
                chk("sb_done", {1'b1, Busy, Nack_err, Al_err, To_err, me.chk_rd ? Rd_data : 8'h00},
                    {me.kind, 1'b0, me.err, me.chk_rd ? me.rd : 8'h00});
            end
        end
        prev_cmd = cur_cmd;
    end

    // Byte controller model: each new command consumes one response entry; dly<0 never completes.
    resp_t r;
    initial forever begin
        @(negedge Clk);
        if (Rst_n && (Start | Stop | Read | Write)) begin
            r.ack = 1'b0; r.rxr = 8'h00; r.dly = 1;
            if (rq.size() != 0) r = rq.pop_front();
            if (r.dly < 0) begin
                while (Start | Stop | Read | Write) @(negedge Clk);
            end else begin
                repeat (r.dly) @(negedge Clk);
                Rx_ack = r.ack; Rxr = r.rxr; I2C_done = 1'b1;
                @(negedge Clk);
                I2C_done = 1'b0; Rx_ack = 1'b0;
            end
        end
    end

    task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        Req_rnw = rnw; Dev_addr = dev; Reg_addr = rg; Wr_data = wd; Req = 1'b1;
        @(negedge Clk);
        Req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int i = 0;
        while (!Done && i < 400) begin
            @(negedge Clk);
            i++;
        end
        chk(nm, Done, 1);
    endtask

    initial begin
        repeat (30000) @(posedge Clk);
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, cnt;
        // reset state, Req ignored while in reset
        Req = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_outs", outs(), 0);
        Req = 1'b0;
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk("idle_outs", outs(), 0);

        // 1 register write
        push_cmd(F_AW, 8'hA0); push_cmd(F_RG, 8'h10); push_cmd(F_WD, 8'hA5); push_done(3'b000, 0, 0);
        repeat (3) push_resp(0, 0, 2);
        do_req(0, 7'h50, 8'h10, 8'hA5);
        chk("lat_gap", {Busy, Start, Write}, 3'b100);
        @(negedge Clk);
        chk("lat_cmd", {Start, Write}, 2'b11);
        wait_done("t1_done");
        repeat (2) @(negedge Clk);

        // 2 register read
        push_cmd(F_AW, 8'hA0); push_cmd(F_RG, 8'h20); push_cmd(F_AW, 8'hA1); push_cmd(F_RD, 8'h00);
        push_done(3'b000, 1, 8'h3C);
        repeat (3) push_resp(0, 0, 1);
        push_resp(0, 8'h3C, 3);
        do_req(1, 7'h50, 8'h20, 8'h00);
        wait_done("t2_done");
        @(negedge Clk);
        chk("t2_rd_hold", Rd_data, 8'h3C);
        repeat (2) @(negedge Clk);

        // 3 address NACK -> stop only
        push_cmd(F_AW, 8'h54); push_cmd(F_NS, 8'h00); push_done(3'b100, 0, 0);
        push_resp(1, 0, 1); push_resp(0, 0, 1);
        do_req(0, 7'h2A, 8'h77, 8'h88);
        wait_done("t3_done");
        repeat (2) @(negedge Clk);

        // 3b data NACK: stop already issued with the data byte
        push_cmd(F_AW, 8'h22); push_cmd(F_RG, 8'h01); push_cmd(F_WD, 8'hFF); push_done(3'b100, 0, 0);
        push_resp(0, 0, 0); push_resp(0, 0, 0); push_resp(1, 0, 0);
        do_req(0, 7'h11, 8'h01, 8'hFF);
        wait_done("t3b_done");
        repeat (2) @(negedge Clk);

        // 3c register NACK on a read
        push_cmd(F_AW, 8'hFE); push_cmd(F_RG, 8'h80); push_cmd(F_NS, 8'h00); push_done(3'b100, 0, 0);
        push_resp(0, 0, 1); push_resp(1, 0, 1); push_resp(0, 0, 1);
        do_req(1, 7'h7F, 8'h80, 8'h00);
        wait_done("t3c_done");
        repeat (2) @(negedge Clk);

        // 4 arbitration lost during the register byte
        push_cmd(F_AW, 8'hA0); push_cmd(F_RG, 8'h33); push_done(3'b010, 0, 0);
        push_resp(0, 0, 1); push_resp(0, 0, -1);
        do_req(0, 7'h50, 8'h33, 8'h44);
        n = 0;
        while (!(Write && Txr == 8'h33) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("t4_reg_seen", Write && Txr == 8'h33, 1);
        I2C_al = 1'b1;
        @(negedge Clk);
        I2C_al = 1'b0;
        chk("t4_drop", {Start, Stop, Read, Write}, 4'b0000);
        wait_done("t4_done");
        repeat (2) @(negedge Clk);

        // 5 Req held high: inputs change mid-transaction, second accept right after FIN
        push_cmd(F_AW, 8'hA0); push_cmd(F_RG, 8'h10); push_cmd(F_WD, 8'h5A); push_done(3'b000, 0, 0);
        push_cmd(F_AW, 8'h02); push_cmd(F_RG, 8'h02); push_cmd(F_WD, 8'h03); push_done(3'b000, 0, 0);
        repeat (6) push_resp(0, 0, 1);
        Req_rnw = 0; Dev_addr = 7'h50; Reg_addr = 8'h10; Wr_data = 8'h5A; Req = 1'b1;
        @(negedge Clk);
        Dev_addr = 7'h01; Reg_addr = 8'h02; Wr_data = 8'h03;
        wait_done("t5_done1");
        for (n = 1; n <= 10; n++) begin
            @(negedge Clk);
            if (Start) break;
        end
        chk("t5_reaccept", n, 3);
        Req = 1'b0;
        wait_done("t5_done2");
        repeat (2) @(negedge Clk);

        // 5b reset in the middle of RDATA
        push_cmd(F_AW, 8'h66); push_cmd(F_RG, 8'h44); push_cmd(F_AW, 8'h67); push_cmd(F_RD, 8'h00);
        repeat (3) push_resp(0, 0, 1);
        push_resp(0, 0, -1);
        do_req(1, 7'h33, 8'h44, 8'h00);
        n = 0;
        while (!Read && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("t5b_read_seen", Read, 1);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("t5b_rst_outs", outs(), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // 6 byte controller never answers
        push_cmd(F_AW, 8'hA0);
        push_resp(0, 0, -1);
`ifdef I2C_SEQ_TIMEOUT_EN
        push_done(3'b001, 0, 0);
        do_req(0, 7'h50, 8'h10, 8'h00);
        cnt = 0;
        n = 0;
        while (!Done && n < 400) begin
            @(negedge Clk);
            cnt += int'(Write);
            n++;
        end
        chk("t6_to_done", Done, 1);
        chk("t6_cmd_cycles", cnt, 100);
`else
        do_req(0, 7'h50, 8'h10, 8'h00);
        repeat (300) @(negedge Clk);
        chk("t6_hang", {Busy, Write, Start, To_err}, 4'b1110);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
`endif
        repeat (3) @(negedge Clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
